// File: rtl/seq_mult_n.sv
// N-bit sequential shift-add multiplier with signed/unsigned mode, start/busy/done
// handshake and early termination once the remaining multiplier bits are zero.
module seq_mult_n #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           sgn,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  logic [0:0]     state;
  logic [2*N-1:0] a_reg;
  logic [N-1:0]   b_reg;
  logic [2*N-1:0] acc;
  logic           neg;
  logic [CW-1:0]  cnt;

  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic           finish;

  // The most negative operand maps to 2^(N-1), which still fits as N-bit unsigned.
  always_comb begin
    a_mag = (sgn && a[N-1]) ? (~a + N'(1)) : a;
    b_mag = (sgn && b[N-1]) ? (~b + N'(1)) : b;
  end

  assign finish = (b_reg == '0) || (cnt == CW'(N));
  assign busy   = (state == CALC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      p     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= {{N{1'b0}}, a_mag};
            b_reg <= b_mag;
            acc   <= '0;
            cnt   <= '0;
            neg   <= sgn & (a[N-1] ^ b[N-1]);
            state <= CALC;
          end
        end
        CALC: begin
          if (finish) begin
            p     <= neg ? (~acc + (2*N)'(1)) : acc;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            if (b_reg[0]) begin
              acc <= acc + a_reg;
            end
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            cnt   <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_n.sv
// Directed bench for seq_mult_n: a 4-bit and an 8-bit instance driven from a
// vector table, plus hand-written busy-start, done-cycle-start and reset sequences.
module tb_seq_mult_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        start4, sgn4, start8, sgn8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  p4;
  logic [15:0] p8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_mult_n #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .sgn(sgn4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .p(p4)
  );

  seq_mult_n #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sgn(sgn8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
  );

  typedef struct {
    bit          n8;
    bit          s;
    logic [7:0]  av;
    logic [7:0]  bv;
    logic [15:0] exp_p;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for done after an accept edge; lat is the number of edges from accept
  // to the edge that raised done, or -1 on timeout.
  task automatic wait_done(input bit n8, output int lat, output int bcnt);
    lat  = -1;
    bcnt = (n8 ? busy8 : busy4) ? 1 : 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (n8 ? done8 : done4) begin
        lat = i;
        break;
      end
      if (n8 ? busy8 : busy4) bcnt++;
    end
  endtask

  task automatic run_op(input bit n8, input bit s, input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output int bcnt);
    @(negedge clk);
    if (n8) begin sgn8 = s; a8 = av; b8 = bv; start8 = 1'b1; end
    else    begin sgn4 = s; a4 = av[3:0]; b4 = bv[3:0]; start4 = 1'b1; end
    @(posedge clk); #1;
    start4 = 1'b0;
    start8 = 1'b0;
    wait_done(n8, lat, bcnt);
  endtask

  initial begin
    int lat, bcnt;
    logic [15:0] pv;

    vecs[0]  = '{1'b0, 1'b0, 8'h07, 8'h0D, 16'h005B, 5};
    vecs[1]  = '{1'b0, 1'b1, 8'h0D, 8'h05, 16'h00F1, 4};
    vecs[2]  = '{1'b0, 1'b1, 8'h08, 8'h08, 16'h0040, 5};
    vecs[3]  = '{1'b0, 1'b1, 8'h0F, 8'h00, 16'h0000, 1};
    vecs[4]  = '{1'b0, 1'b0, 8'h0F, 8'h0F, 16'h00E1, 5};
    vecs[5]  = '{1'b0, 1'b1, 8'h07, 8'h0F, 16'h00F9, 2};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 8'h08, 16'h0000, 5};
    vecs[7]  = '{1'b0, 1'b0, 8'h02, 8'h03, 16'h0006, 3};
    vecs[8]  = '{1'b1, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 9};
    vecs[9]  = '{1'b1, 1'b1, 8'h80, 8'h7F, 16'hC080, 8};
    vecs[10] = '{1'b1, 1'b1, 8'h80, 8'h80, 16'h4000, 9};
    vecs[11] = '{1'b1, 1'b0, 8'h10, 8'h01, 16'h0010, 2};
    vecs[12] = '{1'b1, 1'b1, 8'hFE, 8'hFD, 16'h0006, 3};

    reset = 1'b1;
    start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    #3;
    check("rst_busy4", {31'd0, busy4}, 32'd0);
    check("rst_done4", {31'd0, done4}, 32'd0);
    check("rst_p4", {24'd0, p4}, 32'd0);
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    check("rst_p8", {16'd0, p8}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].n8, vecs[i].s, vecs[i].av, vecs[i].bv, lat, bcnt);
      pv = vecs[i].n8 ? p8 : {8'h00, p4};
      check($sformatf("v%0d_p", i), {16'd0, pv}, {16'd0, vecs[i].exp_p});
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_busy", i), bcnt, vecs[i].exp_lat);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), {31'd0, vecs[i].n8 ? done8 : done4}, 32'd0);
    end

    // start held high with new operands while busy, still high in the done cycle
    @(negedge clk);
    sgn4 = 1'b0; a4 = 4'h7; b4 = 4'hD; start4 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    a4 = 4'h2; b4 = 4'h3;
    wait_done(1'b0, lat, bcnt);
    check("busy_start_lat", lat, 5);
    check("busy_start_p", {24'd0, p4}, 32'h5B);
    @(posedge clk); #1;
    check("done_cycle_accept", {31'd0, busy4}, 32'd1);
    check("done_cycle_done_low", {31'd0, done4}, 32'd0);
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk); #1;
    check("p_holds_during_calc", {24'd0, p4}, 32'h5B);
    lat = -1;
    for (int i = 2; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done4) begin lat = i; break; end
    end
    check("done_cycle_lat", lat, 3);
    check("done_cycle_p", {24'd0, p4}, 32'h06);

    // reset mid-operation
    @(negedge clk);
    sgn4 = 1'b0; a4 = 4'h7; b4 = 4'hD; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy4}, 32'd0);
    check("async_rst_done", {31'd0, done4}, 32'd0);
    check("async_rst_p", {24'd0, p4}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done4 || busy4) bcnt++;
    end
    check("no_done_after_rst", bcnt, 0);
    run_op(1'b0, 1'b0, 8'h03, 8'h05, lat, bcnt);
    check("post_rst_lat", lat, 4);
    check("post_rst_p", {24'd0, p4}, 32'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_mult_n.md
Name: seq_mult_n

Overview:
Parametrised sequential shift-add multiplier with its control FSM built in. It is the next generation of the 4-bit multiplier datapath, generalised to N-bit operands, with a per-operation signed/unsigned mode. It adds a start/busy/done handshake and early termination once the remaining multiplier bits are all zero. It sits between an operand-issuing controller and any consumer of the 2N-bit product.

Parameters:
N, 4, operand width in bits (N >= 2); product width is 2N
CW, $clog2(N+1), width of the internal iteration counter

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a multiply; sampled only in IDLE
sgn  input  1  1 = operands are two's complement; 0 = unsigned; sampled with start
a  input  N  multiplicand; sampled with start
b  input  N  multiplier; sampled with start
busy  output  1  high while an operation is in progress (state CALC)
done  output  1  one-cycle pulse: product is valid
p  output  2N  product register; holds its value until the next completion or reset

Behaviour:
- Reset values (asynchronous, immediate): state = IDLE; busy = 0; done = 0; p = 0; all internal registers = 0. Reset asserted mid-operation aborts the operation; no done pulse is issued.
- Internal registers:
  - A: 2N bits, shifts left.
  - B: N bits, shifts right.
  - ACC: 2N bits.
  - neg: 1 bit.
  - cnt: CW bits.
- IDLE:
  - busy = 0.
  - On an edge with start = 1:
    - A <= zero-extended |a| and B <= |b|.
    - Magnitudes are taken as two's-complement absolute values when sgn = 1, otherwise the raw values are used.
    - ACC <= 0; cnt <= 0.
    - neg <= sgn & (a[N-1] ^ b[N-1]).
    - Next state is CALC.
- CALC: busy = 1. Each edge does one of two things:
  - If B != 0:
    - If B[0] = 1, ACC <= ACC + A (mod 2^2N).
    - A <= A << 1; B <= B >> 1; cnt <= cnt + 1.
    - Remain in CALC.
  - If B == 0:
    - p <= neg ? (~ACC + 1) : ACC.
    - done <= 1 for exactly the next cycle.
    - Next state is IDLE.
- Latency:
  - Let k = (index of the highest set bit of |b|) + 1, with k = 0 when b = 0.
  - done is high in the cycle after the (k+1)th edge following the start-accept edge.
  - Range: minimum 1 cycle (b = 0), maximum N+1 cycles.
  - cnt never exceeds N. As a safety net, cnt == N forces the completion path.
- Handshake:
  - start while busy = 1 is ignored (no queuing).
  - start may be asserted in the same cycle done is high; it is accepted because the state is already IDLE.
  - a, b and sgn may change freely after the accept edge.
- Signed corner cases:
  - |-2^(N-1)| = 2^(N-1) fits in N unsigned bits.
  - (-2^(N-1))^2 = 2^(2N-2) fits in the 2N-bit signed range.
  - No overflow is possible in either mode.
- Zero product with neg = 1: negating 0 yields 0, so p never shows -0 artefacts.
- p changes only on the completion edge or on reset.

Test Plan:
- N=4, sgn=0, a=7, b=13 (k=4), start for one cycle -> busy high for 5 cycles, done pulses 5 cycles after accept, p = 8'h5B (91).
- N=4, sgn=1, a=4'hD (-3), b=4'h5 -> done after 4 cycles, p = 8'hF1 (-15); repeat with a=4'h8, b=4'h8 -> p = 8'h40 (+64) after 5 cycles.
- N=4, b=0, a=4'hF, sgn=1 -> done 1 cycle after accept, p = 8'h00; busy high for exactly 1 cycle.
- Start re-asserted with new operands (a=2, b=3) while busy -> ignored, original product delivered unchanged. Start asserted in the done cycle with a=2, b=3 -> accepted, p = 8'h06 on the next done.
- Reset pulsed mid-CALC -> busy, done and p go to 0 asynchronously, no done pulse follows, and the next start operates normally.
- N=8, sgn=0, a=8'hFF, b=8'hFF -> done after 9 cycles, p = 16'hFE01; sgn=1, a=8'h80, b=8'h7F -> p = 16'hC080 (-16256).
